// File: rtl/rf_dump_reader_pkg.sv
// -----------------------------------------------------------------------------
// rf_dump_reader_pkg
// Shared definitions for the register-file debug dump reader:
//   - dump FSM state encoding
//   - default header tag
//   - header word field layout and a helper that assembles the header word
// -----------------------------------------------------------------------------
package rf_dump_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_FIN
    } dump_state_t;

    localparam logic [15:0] DEFAULT_HEADER_TAG = 16'hD0D0;

    // Header word: {tag[15:0], 3'b0, first_idx[4:0], 3'b0, last_idx[4:0]}
    localparam int unsigned HDR_LAST_OFS  = 0;
    localparam int unsigned HDR_FIRST_OFS = 8;
    localparam int unsigned HDR_TAG_OFS   = 16;

    function automatic logic [31:0] make_header(
        input logic [15:0] tag,
        input logic [4:0]  first,
        input logic [4:0]  last
    );
        logic [31:0] w_hdr;
        w_hdr = '0;
        w_hdr[HDR_TAG_OFS   +: 16] = tag;
        w_hdr[HDR_FIRST_OFS +: 5]  = first;
        w_hdr[HDR_LAST_OFS  +: 5]  = last;
        return w_hdr;
    endfunction

endpackage

// File: rtl/rf_dump_reader.sv
// -----------------------------------------------------------------------------
// rf_dump_reader
// Walks a register index range on the register file's debug read port and
// streams the values over a valid/ready word stream, with an optional header
// word in front and an optional XOR checksum word at the end.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst        asynchronous active-high reset
//   start      one-cycle dump request (ignored while busy)
//   first_idx  first register index, sampled on start acceptance
//   last_idx   last register index (inclusive), sampled on start acceptance
//   reg_sel    register index driven to the debug read port
//   reg_data   combinational read data for reg_sel
//   out_valid  stream word valid
//   out_ready  downstream accepts the word
//   out_data   stream word
//   out_last   final word of the dump
//   busy       dump in progress
//   done       one-cycle pulse after the final handshake
//   err        one-cycle pulse when start is rejected (first_idx > last_idx)
// -----------------------------------------------------------------------------
module rf_dump_reader
    import rf_dump_reader_pkg::*;
#(
    parameter bit          HEADER_EN   = 1'b1,
    parameter bit          CHECKSUM_EN = 1'b1,
    parameter logic [15:0] HEADER_TAG  = DEFAULT_HEADER_TAG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  first_idx,
    input  logic [4:0]  last_idx,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    dump_state_t r_state, w_state;
    logic [4:0]  r_sel, w_sel;
    logic [4:0]  r_last_idx, w_last_idx;
    logic [31:0] r_data, w_data;
    logic        r_valid, w_valid;
    logic        r_olast, w_olast;
    logic        r_cur_last, w_cur_last;   // word in r_data is the final data word
    logic [31:0] r_csum, w_csum;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_err, w_err;

    logic w_can_start;
    logic w_accept;
    logic w_reject;
    logic w_hs;

    // FIN behaves like IDLE for start so a new dump can begin while done is high.
    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_FIN);
    assign w_accept    = w_can_start && start && (first_idx <= last_idx);
    assign w_reject    = w_can_start && start && (first_idx > last_idx);
    assign w_hs        = r_valid && out_ready;

    // Without a header the first data word is loaded on the accepting edge, so
    // the read port must see first_idx during that cycle.
    generate
        if (HEADER_EN) begin : g_sel_reg
            assign reg_sel = r_sel;
        end else begin : g_sel_bypass
            assign reg_sel = w_accept ? first_idx : r_sel;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_last_idx <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_olast    <= 1'b0;
            r_cur_last <= 1'b0;
            r_csum     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_sel      <= w_sel;
            r_last_idx <= w_last_idx;
            r_data     <= w_data;
            r_valid    <= w_valid;
            r_olast    <= w_olast;
            r_cur_last <= w_cur_last;
            r_csum     <= w_csum;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_sel      = r_sel;
        w_last_idx = r_last_idx;
        w_data     = r_data;
        w_valid    = r_valid;
        w_olast    = r_olast;
        w_cur_last = r_cur_last;
        w_csum     = r_csum;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_err      = 1'b0;

        case (r_state)
            ST_IDLE, ST_FIN: begin
                w_state = ST_IDLE;
                if (w_accept) begin
                    w_last_idx = last_idx;
                    w_busy     = 1'b1;
                    w_valid    = 1'b1;
                    if (HEADER_EN) begin
                        w_state    = ST_HDR;
                        w_data     = make_header(HEADER_TAG, first_idx, last_idx);
                        w_olast    = 1'b0;
                        w_cur_last = 1'b0;
                        w_sel      = first_idx;
                        w_csum     = '0;
                    end else begin
                        w_state    = ST_DATA;
                        w_data     = reg_data;
                        w_csum     = reg_data;
                        w_cur_last = (first_idx == last_idx);
                        w_olast    = w_cur_last && !CHECKSUM_EN;
                        // Hold at the last index so last_idx=31 never wraps.
                        w_sel      = w_cur_last ? first_idx : first_idx + 5'd1;
                    end
                end else if (w_reject) begin
                    w_err = 1'b1;
                end
            end

            ST_HDR, ST_DATA: begin
                if (w_hs) begin
                    if ((r_state == ST_DATA) && r_cur_last) begin
                        if (CHECKSUM_EN) begin
                            w_state    = ST_CSUM;
                            w_data     = r_csum;
                            w_olast    = 1'b1;
                            w_cur_last = 1'b0;
                        end else begin
                            w_state = ST_FIN;
                            w_valid = 1'b0;
                            w_olast = 1'b0;
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                        end
                    end else begin
                        w_state    = ST_DATA;
                        w_data     = reg_data;
                        w_csum     = r_csum ^ reg_data;
                        w_cur_last = (r_sel == r_last_idx);
                        w_olast    = w_cur_last && !CHECKSUM_EN;
                        w_sel      = w_cur_last ? r_sel : r_sel + 5'd1;
                    end
                end
            end

            ST_CSUM: begin
                if (w_hs) begin
                    w_state = ST_FIN;
                    w_valid = 1'b0;
                    w_olast = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end
            end

            default: w_state = ST_IDLE;
        endcase
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_last  = r_olast;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_rf_dump_reader.sv
`timescale 1ns/1ps
module tb_rf_dump_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] rf [32];

    // DUT A: header + checksum
    logic        start_a, valid_a, ready_a, olast_a, busy_a, done_a, err_a;
    logic [4:0]  first_a, last_a, sel_a;
    logic [31:0] rd_a, data_a;
    // DUT B: no header, no checksum
    logic        start_b, valid_b, ready_b, olast_b, busy_b, done_b, err_b;
    logic [4:0]  first_b, last_b, sel_b;
    logic [31:0] rd_b, data_b;

    assign rd_a = (sel_a == 5'd0) ? 32'h0 : rf[sel_a];
    assign rd_b = (sel_b == 5'd0) ? 32'h0 : rf[sel_b];

    rf_dump_reader #(.HEADER_EN(1'b1), .CHECKSUM_EN(1'b1), .HEADER_TAG(16'hD0D0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .first_idx(first_a), .last_idx(last_a),
        .reg_sel(sel_a), .reg_data(rd_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_data(data_a), .out_last(olast_a), .busy(busy_a), .done(done_a), .err(err_a));

    rf_dump_reader #(.HEADER_EN(1'b0), .CHECKSUM_EN(1'b0), .HEADER_TAG(16'hD0D0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .first_idx(first_b), .last_idx(last_b),
        .reg_sel(sel_b), .reg_data(rd_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_data(data_b), .out_last(olast_b), .busy(busy_b), .done(done_b), .err(err_b));

    int total = 0;
    int bad   = 0;
    logic [32:0] q_a [$];
    logic [32:0] q_b [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic        pv_a = 1'b0, pr_a = 1'b0;
    logic [32:0] pw_a = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv_a <= 1'b0;
        end else begin
            if (pv_a && !pr_a) begin
                chk("hold_valid_a", {63'b0, valid_a}, 64'd1);
                chk("hold_word_a", {31'b0, olast_a, data_a}, {31'b0, pw_a});
            end
            if (valid_a && ready_a) begin
                if (q_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word_a: got %h expected no word", {olast_a, data_a});
                end else begin
                    chk("word_a", {31'b0, olast_a, data_a}, {31'b0, q_a.pop_front()});
                end
            end
            pv_a <= valid_a;
            pr_a <= ready_a;
            pw_a <= {olast_a, data_a};
        end
    end

    logic        pv_b = 1'b0, pr_b = 1'b0;
    logic [32:0] pw_b = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv_b <= 1'b0;
        end else begin
            if (pv_b && !pr_b) begin
                chk("hold_valid_b", {63'b0, valid_b}, 64'd1);
                chk("hold_word_b", {31'b0, olast_b, data_b}, {31'b0, pw_b});
            end
            if (valid_b && ready_b) begin
                if (q_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word_b: got %h expected no word", {olast_b, data_b});
                end else begin
                    chk("word_b", {31'b0, olast_b, data_b}, {31'b0, q_b.pop_front()});
                end
            end
            pv_b <= valid_b;
            pr_b <= ready_b;
            pw_b <= {olast_b, data_b};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input bit use_b, input logic lst, input logic [31:0] w);
        if (use_b) q_b.push_back({lst, w});
        else       q_a.push_back({lst, w});
    endtask

    task automatic start_dump(input bit use_b, input logic [4:0] f, input logic [4:0] l);
        if (use_b) begin start_b = 1'b1; first_b = f; last_b = l; end
        else       begin start_a = 1'b1; first_a = f; last_a = l; end
        @(posedge clk); #1;
        if (use_b) start_b = 1'b0;
        else       start_a = 1'b0;
    endtask

    // Called in the first cycle after acceptance; returns in the cycle done is high.
    task automatic wait_done(input bit use_b, input bit stall, input bit live_wr,
                             input bit busy_start, input int unsigned exp_cyc);
        int unsigned k;
        bit seen;
        bit wrapped;
        k = 1; seen = 1'b0; wrapped = 1'b0;
        while (!seen && k < 400) begin
            if ((use_b ? done_b : done_a) == 1'b1) begin
                seen = 1'b1;
            end else begin
                if (use_b) ready_b = stall ? (k % 3 == 1) : 1'b1;
                else       ready_a = stall ? (k % 3 == 1) : 1'b1;
                if (live_wr && k == 2) rf[7] = 32'hDEAD_BEEF;
                if (busy_start && k == 2) begin start_a = 1'b1; first_a = 5'd9; last_a = 5'd2; end
                if (busy_start && k == 3) begin
                    start_a = 1'b0;
                    chk("busy_start_no_err", {63'b0, err_a}, 64'd0);
                end
                if (use_b && busy_b && sel_b == 5'd0) wrapped = 1'b1;
                @(posedge clk); #1;
                k++;
            end
        end
        chk("done_seen", {63'b0, seen}, 64'd1);
        if (exp_cyc != 0) chk("dump_cycles", {32'b0, k}, {32'b0, exp_cyc});
        if (use_b) chk("sel_no_wrap", {63'b0, wrapped}, 64'd0);
        chk("idle_at_done", use_b ? {62'b0, busy_b, valid_b} : {62'b0, busy_a, valid_a}, 64'd0);
    endtask

    task automatic end_chk(input bit use_b);
        @(posedge clk); #1;
        chk("done_one_cycle", {63'b0, use_b ? done_b : done_a}, 64'd0);
        chk("sb_drained", use_b ? q_b.size() : q_a.size(), 64'd0);
        if (use_b) ready_b = 1'b1;
        else       ready_a = 1'b1;
    endtask

    task automatic push_full_a();
        push(1'b0, 1'b0, 32'hD0D0_001F);
        push(1'b0, 1'b0, 32'h0);
        for (int i = 1; i < 32; i++) push(1'b0, 1'b0, 32'h1000_0000 + i);
        // 31 copies of 0x1000_0000 leave 0x1000_0000; XOR of 1..31 is 0
        push(1'b0, 1'b1, 32'h1000_0000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        start_a = 1'b0; first_a = '0; last_a = '0; ready_a = 1'b1;
        start_b = 1'b0; first_b = '0; last_b = '0; ready_b = 1'b1;
        rf[0] = 32'h0;
        for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        #12;
        chk("reset_a", {22'b0, valid_a, olast_a, busy_a, done_a, err_a, data_a, sel_a}, 64'd0);
        chk("reset_b", {22'b0, valid_b, olast_b, busy_b, done_b, err_b, data_b, sel_b}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full dump, 34 words back-to-back
        push_full_a();
        start_dump(1'b0, 5'd0, 5'd31);
        chk("first_valid", {62'b0, valid_a, busy_a}, 64'd3);
        wait_done(1'b0, 1'b0, 1'b0, 1'b0, 35);
        end_chk(1'b0);

        // Backpressure 3..5 with an ignored start while busy
        push(1'b0, 1'b0, 32'hD0D0_0305);
        push(1'b0, 1'b0, 32'h1000_0003);
        push(1'b0, 1'b0, 32'h1000_0004);
        push(1'b0, 1'b0, 32'h1000_0005);
        push(1'b0, 1'b1, 32'h1000_0002);
        start_dump(1'b0, 5'd3, 5'd5);
        wait_done(1'b0, 1'b1, 1'b0, 1'b1, 14);
        end_chk(1'b0);

        // No header/checksum: single word at index 31
        push(1'b1, 1'b1, 32'h1000_001F);
        start_dump(1'b1, 5'd31, 5'd31);
        chk("single_sel", {59'b0, sel_b}, 64'd31);
        wait_done(1'b1, 1'b0, 1'b0, 1'b0, 2);
        end_chk(1'b1);

        // No header/checksum: 3..5, then restart on the done cycle with 31..31
        push(1'b1, 1'b0, 32'h1000_0003);
        push(1'b1, 1'b0, 32'h1000_0004);
        push(1'b1, 1'b1, 32'h1000_0005);
        start_dump(1'b1, 5'd3, 5'd5);
        wait_done(1'b1, 1'b0, 1'b0, 1'b0, 4);
        push(1'b1, 1'b1, 32'h1000_001F);
        start_dump(1'b1, 5'd31, 5'd31);
        chk("restart_on_done", {62'b0, valid_b, busy_b}, 64'd3);
        wait_done(1'b1, 1'b0, 1'b0, 1'b0, 2);
        end_chk(1'b1);

        // Rejected start
        start_dump(1'b0, 5'd9, 5'd2);
        chk("reject_err", {61'b0, err_a, valid_a, busy_a}, 64'd4);
        @(posedge clk); #1;
        chk("reject_after", {60'b0, err_a, valid_a, busy_a, done_a}, 64'd0);

        // Live write of x7 during a stalled dump 4..8
        push(1'b0, 1'b0, 32'hD0D0_0408);
        push(1'b0, 1'b0, 32'h1000_0004);
        push(1'b0, 1'b0, 32'h1000_0005);
        push(1'b0, 1'b0, 32'h1000_0006);
        push(1'b0, 1'b0, 32'hDEAD_BEEF);
        push(1'b0, 1'b0, 32'h1000_0008);
        push(1'b0, 1'b1, 32'hDEAD_BEE0);
        start_dump(1'b0, 5'd4, 5'd8);
        wait_done(1'b0, 1'b1, 1'b1, 1'b0, 20);
        end_chk(1'b0);
        rf[7] = 32'h1000_0007;

        // Reset after two handshakes, then a full replay
        push_full_a();
        start_dump(1'b0, 5'd0, 5'd31);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midreset_out", {22'b0, valid_a, olast_a, busy_a, done_a, err_a, data_a, sel_a}, 64'd0);
        chk("midreset_popped", q_a.size(), 64'd32);
        q_a.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midreset_no_done", {63'b0, done_a}, 64'd0);
        push_full_a();
        start_dump(1'b0, 5'd0, 5'd31);
        wait_done(1'b0, 1'b0, 1'b0, 1'b0, 35);
        end_chk(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
Debug-side reader for the CPU register file's debug read port (reg_sel / reg_data). On a start pulse it walks a register index range and streams the values out over a valid/ready word stream. The stream has an optional header word and an optional trailing XOR checksum word. It sits beside the register file and feeds the debug/trace path (UART framer or trace FIFO); it never writes the register file.

Parameters:
HEADER_EN, 1, emit a header word before the data words
CHECKSUM_EN, 1, emit an XOR-checksum word after the data words
HEADER_TAG, 16'hD0D0, upper 16 bits of the header word

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a dump; ignored while busy
first_idx  in  5  first register index, sampled when start is accepted
last_idx  in  5  last register index (inclusive), sampled when start is accepted
reg_sel  out  5  register index driven to the register file's debug read port
reg_data  in  32  combinational read data for reg_sel (index 0 returns 0)
out_valid  out  1  stream word valid
out_ready  in  1  downstream accepts the word
out_data  out  32  stream word
out_last  out  1  marks the final word of the dump
busy  out  1  dump in progress (start accepted, final handshake not yet done)
done  out  1  one-cycle pulse the cycle after the final handshake
err  out  1  one-cycle pulse when start is rejected because first_idx > last_idx

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all outputs 0. State IDLE. Checksum accumulator 0.
- States:
  - IDLE -> HDR if HEADER_EN, else IDLE -> DATA.
  - HDR -> DATA.
  - DATA -> CSUM if CHECKSUM_EN, else DATA -> FIN.
  - CSUM -> FIN.
  - FIN -> IDLE.
- Start acceptance: start is accepted only in IDLE with first_idx <= last_idx.
  - Accepted at cycle T: busy=1 and out_valid=1 from T+1.
  - First word at T+1 is the header, or reg_data[first_idx] if HEADER_EN=0.
- Rejected start: in IDLE with first_idx > last_idx, err=1 for exactly one cycle (T+1). No stream, no done, stays IDLE.
- Start while busy: no effect, no err.
- Header word: {HEADER_TAG, 3'b0, first_idx, 3'b0, last_idx}.
- reg_sel is registered and always holds the index of the next data word to load.
  - A data word is loaded into out_data from reg_data on the clock edge where the previous word handshakes, or on entry to DATA.
  - Sustained throughput is 1 word/cycle when out_ready stays high.
- Handshake: a transfer happens when out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
- Index stepping:
  - The index increments after each data handshake.
  - The end test is idx == last_idx, checked before incrementing. last_idx=31 must not wrap to 0 and restart.
  - first_idx == last_idx yields exactly one data word.
- Checksum: XOR of every data word as loaded into out_data. The header is excluded. The accumulator clears on start acceptance.
- Word count: HEADER_EN + (last_idx - first_idx + 1) + CHECKSUM_EN.
  - out_last=1 only on the final word. With CHECKSUM_EN=0 that is the last data word.
- Completion: after the final handshake, out_valid=0, busy=0 and done=1 for one cycle. A new start is accepted on the same cycle done is high.
- Values are live reads, not a snapshot. A register written by the CPU during the dump shows its new value if its index has not yet been loaded. The register file's write bypass applies.
- Reset mid-dump: the stream aborts immediately, all outputs go to 0, and no out_last or done is produced.

Decomposition:
- Shared debug package holds:
  - the state encoding (IDLE, HDR, DATA, CSUM, FIN);
  - the HEADER_TAG default;
  - the header field layout constants (index field offsets 0 and 8, tag offset 16).
- No sub-module is needed. The output word register plus valid/hold logic may be factored as stream_out_reg if the trace path reuses it.

Test Plan:
- Full dump: registers preset x1..x31 = 32'h1000_0000+i; first=0, last=31, out_ready=1, both flags set -> 34 consecutive words: header 32'hD0D0_001F, then 0, 32'h1000_0001 .. 32'h1000_001F, then XOR checksum; out_last only on word 34; done one cycle later.
- Backpressure: first=3, last=5, out_ready toggled 1,0,0,1,... -> out_data stable across stalls; sequence 32'hD0D0_0305, x3, x4, x5, checksum = x3^x4^x5.
- Single and boundary: first=last=31 with HEADER_EN=0, CHECKSUM_EN=0 -> one word x31 with out_last=1; reg_sel never wraps to 0.
- Reject: first=9, last=2 -> err pulse at T+1, out_valid stays 0, busy stays 0, no done.
- Live write: during a stalled dump of 4..8, CPU writes x7=32'hDEAD_BEEF before index 7 loads -> stream carries 32'hDEAD_BEEF and the checksum reflects it.
- Reset mid-dump: assert rst after 2 handshakes -> all outputs 0 asynchronously; next start replays the full stream from the header.
